nibble_serial_addsub_ctrl: RTL and testbench

Sequencer that performs a multi-nibble add or subtract by driving one 4-bit adder/subtractor slice serially, least-significant nibble first, and chaining the carry between nibbles in a register. It sits between the lab's operand/control logic (switches, command FSM) and the shared 4-bit arithmetic datapath. It provides a start/busy/done handshake so that wide arithmetic reuses one nibble slice.

---
 rtl/nibble_serial_addsub_ctrl.sv | 115 +++++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub_ctrl.sv
// Serial multi-nibble add/subtract sequencer driving a single 4-bit slice, LS nibble first.
// Optional macro ADDSUB_OVERFLOW_EN enables signed-overflow detection; otherwise o_overflow is tied to 0.
module nibble_serial_addsub_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_sub,
    input  logic [4*NIBBLES-1:0]   i_op_a,
    input  logic [4*NIBBLES-1:0]   i_op_b,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [4*NIBBLES-1:0]   o_result,
    output logic                   o_carry_out,
    output logic                   o_overflow
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned SH_W  = IDX_W + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_sub;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;

    logic [SH_W-1:0]    w_sh;
    logic [3:0]         w_a;
    logic [3:0]         w_b;
    logic [4:0]         w_sum;
    logic               w_last;
    logic [W-1:0]       w_mask;
    logic [W-1:0]       w_ins;
    logic               w_ovf;

    // Current nibble slice; B is inverted for subtract, the +1 comes from the seeded carry.
    assign w_sh   = {r_idx, 2'b00};
    assign w_a    = 4'(r_a >> w_sh);
    assign w_b    = 4'(r_b >> w_sh) ^ {4{r_sub}};
    assign w_sum  = 5'(w_a) + 5'(w_b) + 5'(r_carry);
    assign w_last = (r_idx == IDX_W'(NIBBLES - 1));
    assign w_mask = ~(W'(4'hF) << w_sh);
    assign w_ins  = W'(w_sum[3:0]) << w_sh;

`ifdef ADDSUB_OVERFLOW_EN
    // Carry into bit 3 recovered as a3^b3^s3, compared with the carry out of bit 3.
    assign w_ovf = w_a[3] ^ w_b[3] ^ w_sum[3] ^ w_sum[4];
`else
    assign w_ovf = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_sub       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_result    <= '0;
            o_carry_out <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_a      <= i_op_a;
                        r_b      <= i_op_b;
                        r_sub    <= i_sub;
                        r_carry  <= i_sub;
                        r_idx    <= '0;
                        o_result <= '0;
                        o_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    o_result <= (o_result & w_mask) | w_ins;
                    r_carry  <= w_sum[4];
                    r_idx    <= r_idx + 1'b1;
                    if (w_last) begin
                        o_carry_out <= w_sum[4];
                        o_overflow  <= w_ovf;
                        o_done      <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Scoreboard bench for nibble_serial_addsub_ctrl: randomized and directed ops vs. an arithmetic model.
module tb_nibble_serial_addsub_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;
`ifdef ADDSUB_OVERFLOW_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_result;
    logic         o_carry_out;
    logic         o_overflow;

    nibble_serial_addsub_ctrl #(.NIBBLES(N)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_sub       (sub),
        .i_op_a      (a),
        .i_op_b      (b),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_result    (o_result),
        .o_carry_out (o_carry_out),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int unsigned  done_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_co = 1'b0;
    logic prev_ov = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference: plain wide arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int unsigned dc);
        exp_t   e;
        longint sx;
        longint sy;
        longint sr;
        longint ux;
        longint uy;
        ux = longint'(x);
        uy = longint'(y);
        sx = (x[W-1]) ? ux - (64'sd1 << W) : ux;
        sy = (y[W-1]) ? uy - (64'sd1 << W) : uy;
        if (s) begin
            e.res = W'(ux - uy);
            e.co  = (ux >= uy);
            sr    = sx - sy;
        end else begin
            e.res = W'(ux + uy);
            e.co  = ((ux + uy) >= (64'sd1 << W));
            sr    = sx + sy;
        end
        e.ov = OVF_ON & ((sr >= (64'sd1 << (W - 1))) || (sr < -(64'sd1 << (W - 1))));
        e.done_cyc = dc;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (o_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no done (cyc=%0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("result",       32'(o_result),    32'(e.res));
                chk("carry_out",    32'(o_carry_out), 32'(e.co));
                chk("overflow",     32'(o_overflow),  32'(e.ov));
                chk("done_latency", cyc,              e.done_cyc);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Issue one op from IDLE; checks busy, result clear and held flags after the accepting edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        a     = x;
        b     = y;
        sub   = s;
        start = 1'b1;
        e     = model(x, y, s, cyc + N + 1);
        sb.push_back(e);
        step();
        start = 1'b0;
        chk("busy_after_accept", 32'(o_busy),      32'd1);
        chk("result_cleared",    32'(o_result),    32'd0);
        chk("carry_held",        32'(o_carry_out), 32'(prev_co));
        chk("ovf_held",          32'(o_overflow),  32'(prev_ov));
        prev_co = e.co;
        prev_ov = e.ov;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            step();
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        step();
        chk("busy_idle", 32'(o_busy), 32'd0);
    endtask

    initial begin
        int pushed;
        int g;
        int unsigned nxt;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        step();
        step();
        chk("rst_busy",   32'(o_busy),   32'd0);
        chk("rst_result", 32'(o_result), 32'd0);
        rst = 1'b0;

        // Idle with no start.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_busy", 32'(o_busy), 32'd0);
            chk("idle_done", 32'(o_done), 32'd0);
        end
        chk("idle_result", 32'(o_result),    32'd0);
        chk("idle_co",     32'(o_carry_out), 32'd0);
        chk("idle_ov",     32'(o_overflow),  32'd0);

        issue(16'h1234, 16'h0FFF, 1'b0); drain();
        chk("t2_result", 32'(o_result), 32'h2233);
        issue(16'h0000, 16'h0001, 1'b1); drain();
        chk("t3_result", 32'(o_result),    32'hFFFF);
        chk("t3_co",     32'(o_carry_out), 32'd0);
        issue(16'h7FFF, 16'h0001, 1'b0); drain();
        chk("t4_result", 32'(o_result),   32'h8000);
        chk("t4_ov",     32'(o_overflow), 32'(OVF_ON));

        // Starts and operand changes while busy must be ignored.
        issue(16'hFFFF, 16'h0001, 1'b0);
        a = W'($urandom); b = W'($urandom); sub = 1'b1; start = 1'b1;
        step();
        a = W'($urandom); b = W'($urandom);
        step();
        start = 1'b0;
        drain();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("no_second_op", 32'(o_busy), 32'd0);
        end
        chk("t5_result", 32'(o_result),    32'h0000);
        chk("t5_co",     32'(o_carry_out), 32'd1);

        // Asynchronous reset mid-run discards the op.
        issue(W'($urandom), W'($urandom), 1'($urandom));
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy",   32'(o_busy),      32'd0);
        chk("arst_done",   32'(o_done),      32'd0);
        chk("arst_result", 32'(o_result),    32'd0);
        chk("arst_co",     32'(o_carry_out), 32'd0);
        chk("arst_ov",     32'(o_overflow),  32'd0);
        sb.delete();
        prev_co = 1'b0;
        prev_ov = 1'b0;
        step();
        rst = 1'b0;
        repeat (6) step();
        issue(16'h8000, 16'h0001, 1'b1); drain();
        chk("t6_result", 32'(o_result),    32'h7FFF);
        chk("t6_co",     32'(o_carry_out), 32'd1);
        chk("t6_ov",     32'(o_overflow),  32'(OVF_ON));

        // Random single ops.
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            drain();
        end

        // start held high: accepts every N+2 cycles, operands churning meanwhile.
        start  = 1'b1;
        pushed = 0;
        g      = 0;
        nxt    = cyc;
        while (pushed < 12 && g < 200) begin
            a   = W'($urandom);
            b   = W'($urandom);
            sub = 1'($urandom);
            if (cyc == nxt) begin
                sb.push_back(model(a, b, sub, cyc + N + 1));
                nxt += N + 2;
                pushed++;
            end
            step();
            g++;
        end
        start = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
